// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder with zero-tail frame termination.
// Define CONV_ENC_SYM_CNT_EN to add the per-frame accepted-symbol counter (sym_cnt).
module conv_enc_k7 #(
    parameter int unsigned    K  = 7,
    parameter logic [K-1:0]   G0 = 7'b1111001,
    parameter logic [K-1:0]   G1 = 7'b1011011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_pair,
    output logic        out_last
`ifdef CONV_ENC_SYM_CNT_EN
    ,
    output logic [15:0] sym_cnt
`endif
);

    localparam int unsigned TCW = $clog2(K - 1);

    typedef enum logic {DATA, TAIL} state_t;

    state_t           state;
    logic [K-2:0]     sr;
    logic [TCW-1:0]   tail_cnt;
    logic             alive;

    logic             out_free;
    logic             accept;
    logic             produce;
    logic             cur_bit;
    logic             tail_end;
    logic [K-1:0]     v;
    logic [1:0]       pair_next;

    // alive keeps in_ready low while reset is held and for the first edge after release
    assign out_free = !out_valid || out_ready;
    assign in_ready = alive && (state == DATA) && out_free;
    assign accept   = in_valid && in_ready;
    assign produce  = accept || ((state == TAIL) && out_free);
    assign cur_bit  = (state == DATA) ? in_bit : 1'b0;
    assign tail_end = (state == TAIL) && (tail_cnt == TCW'(K - 2));

    always_comb begin
        v         = {sr, cur_bit};
        pair_next = '0;
        for (int unsigned i = 0; i < K; i++) begin
            pair_next[0] = pair_next[0] ^ (G0[K-1-i] & v[i]);
            pair_next[1] = pair_next[1] ^ (G1[K-1-i] & v[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DATA;
            sr        <= '0;
            tail_cnt  <= '0;
            alive     <= 1'b0;
            out_valid <= 1'b0;
            out_pair  <= '0;
            out_last  <= 1'b0;
        end else begin
            alive <= 1'b1;

            if (produce) begin
                sr        <= {sr[K-3:0], cur_bit};
                out_valid <= 1'b1;
                out_pair  <= pair_next;
                out_last  <= tail_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                DATA: begin
                    if (accept && in_last) begin
                        state    <= TAIL;
                        tail_cnt <= '0;
                    end
                end
                TAIL: begin
                    if (out_free) begin
                        if (tail_end) begin
                            state    <= DATA;
                            tail_cnt <= '0;
                        end else begin
                            tail_cnt <= tail_cnt + TCW'(1);
                        end
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

`ifdef CONV_ENC_SYM_CNT_EN
    // The final count stays visible for one cycle after out_last is taken, then clears.
    logic cnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
            cnt_clr <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (cnt_clr)
                    sym_cnt <= 16'd1;
                else if (sym_cnt != 16'hFFFF)
                    sym_cnt <= sym_cnt + 16'd1;
                cnt_clr <= out_last;
            end else begin
                if (cnt_clr)
                    sym_cnt <= '0;
                cnt_clr <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_enc_k7.sv
// Scoreboard bench for conv_enc_k7: randomized frames checked against a convolution-sum model.
`timescale 1ns/1ps
module tb_conv_enc_k7;

    localparam logic [6:0] G0 = 7'b1111001;
    localparam logic [6:0] G1 = 7'b1011011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_pair;
`ifdef CONV_ENC_SYM_CNT_EN
    logic [15:0] sym_cnt;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [2:0]  exp_q[$];
    logic        frame_q[$];
    int          ready_mode = 0;
    int unsigned gap_pct = 0;

    conv_enc_k7 #(.K(7), .G0(G0), .G1(G1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last)
`ifdef CONV_ENC_SYM_CNT_EN
        ,
        .sym_cnt   (sym_cnt)
`endif
    );

    always #5 clk = ~clk;

    // out_ready changes just after the rising edge: 0 = high, 1 = random, 2 = low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected symbols: out_j[n] = XOR_i Gj[6-i] * u[n-i], u = frame bits followed by 6 zeros
    task automatic push_expected();
        logic u[$];
        logic p0;
        logic p1;
        u = frame_q;
        repeat (6) u.push_back(1'b0);
        for (int n = 0; n < u.size(); n++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (n - i >= 0) begin
                    p0 = p0 ^ (G0[6-i] & u[n-i]);
                    p1 = p1 ^ (G1[6-i] & u[n-i]);
                end
            end
            exp_q.push_back({(n == int'(u.size()) - 1), p1, p0});
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last bit is accepted
    task automatic send_frame();
        int n;
        int cyc;
        n = frame_q.size();
        push_expected();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(1));
                in_last  = 1'($urandom_range(1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_bit   = frame_q[i];
            in_last  = (i == n - 1);
            cyc = 0;
            while (!in_ready && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", cyc);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops on every handshake, and checks the output holds while stalled
    initial begin
        logic       stall;
        logic [2:0] held;
        logic [2:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_symbol", {out_last, out_pair}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_symbol: got %b required none", {out_last, out_pair});
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", {out_last, out_pair}, e);
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_last, out_pair};
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pair", out_pair, 0);
        check("reset_out_last", out_last, 0);
        check("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 1 bit: 7 symbols, in_ready low through the six tail cycles
        frame_q = '{1'b1};
        send_frame();
        for (int i = 0; i < 6; i++) begin
            check("tail_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check("post_tail_in_ready", in_ready, 1);
        wait_idle("frame_1bit_drain");

        // 1,0 frame then a single 0 bit proving sr returned to zero
        frame_q = '{1'b1, 1'b0};
        send_frame();
        frame_q = '{1'b0};
        send_frame();
        wait_idle("frame_2bit_drain");

        // Backpressure on the first symbol
        ready_mode = 2;
        @(negedge clk);
        frame_q = '{1'b1};
        send_frame();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_pair", out_pair, 2'b11);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        ready_mode = 0;
        wait_idle("stall_drain");

        // Two back-to-back 3-bit frames under random out_ready
        ready_mode = 1;
        for (int f = 0; f < 2; f++) begin
            frame_q.delete();
            for (int i = 0; i < 3; i++) frame_q.push_back(1'($urandom_range(1)));
            send_frame();
        end
        ready_mode = 0;
        wait_idle("b2b_drain");

        // Reset in the middle of the tail
        frame_q = '{1'b1, 1'b0, 1'b1};
        send_frame();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_last", out_last, 0);
        check("midreset_in_ready", in_ready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_q = '{1'b1};
        send_frame();
        wait_idle("after_reset_drain");

        // Random frames, random input gaps and random out_ready
        ready_mode = 1;
        gap_pct = 30;
        for (int f = 0; f < 20; f++) begin
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(12, 1)); i++)
                frame_q.push_back(1'($urandom_range(1)));
            send_frame();
        end
        ready_mode = 0;
        gap_pct = 0;
        wait_idle("random_drain");

`ifdef CONV_ENC_SYM_CNT_EN
        begin
            int cyc;
            frame_q.delete();
            for (int i = 0; i < 4; i++) frame_q.push_back(1'($urandom_range(1)));
            send_frame();
            cyc = 0;
            while (!(out_valid && out_ready && out_last) && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
            check("sym_cnt_final", sym_cnt, 10);
            @(negedge clk);
            check("sym_cnt_cleared", sym_cnt, 0);
            wait_idle("sym_cnt_drain");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
